// File: rtl/fsb_seq_pkg.sv
// Shared FSB definitions: sequencer state encoding and counter widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fsb_seq_pkg;

  localparam int CNT_W  = 8;  // timeout counter width
  localparam int ROMW_W = 4;  // ROM wait counter width (ROMWS is 0..15)

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ROMW       = 3'd1,
    S_RAMW       = 3'd2,
    S_IOWAITIDLE = 3'd3,
    S_IOREQ      = 3'd4,
    S_DONE       = 3'd5,
    S_ERR        = 3'd6
  } state_t;

endpackage

// File: rtl/fsb_seq_if.sv
// FSB sequencer bus bundle: selects and ready sources in, ready/error/IO request out.
// Latency: n/a (wires only).
// Backpressure: n/a; the 68000 cycle is held by BACT until a ready or error returns.
interface fsb_seq_if;

  logic BACT;
  logic IACS;
  logic ROMCS;
  logic RAMCS;
  logic IOCS;
  logic RAMReady;
  logic IOACK;
  logic IOBERR;
  logic IOREQ;
  logic Ready0;
  logic Ready1;
  logic BERR0;

  // Bus / environment side: drives the cycle and the completion sources.
  modport master (
    output BACT, IACS, ROMCS, RAMCS, IOCS, RAMReady, IOACK, IOBERR,
    input  IOREQ, Ready0, Ready1, BERR0
  );

  // Sequencer side.
  modport slave (
    input  BACT, IACS, ROMCS, RAMCS, IOCS, RAMReady, IOACK, IOBERR,
    output IOREQ, Ready0, Ready1, BERR0
  );

endinterface

// File: rtl/fsb_seq_timeout.sv
// Saturating wait-state counter; flags expiry on the cycle that is the TIMEOUT-th counted one.
// Latency: expired_o is combinational from the count register and en_i only (no bus input path).
// Backpressure: none; counts while en_i, holds at timeout_i, cleared by clr_i.
module fsb_timeout
  import fsb_seq_pkg::*;
(
  input  logic             FCLK,
  input  logic             nRES,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] timeout_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up while enabled and stop at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q < timeout_i)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge FCLK or negedge nRES) begin
    if (!nRES) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This cycle's increment brings the count to the limit, so leave on this edge.
  assign expired_o = en_i && (cnt_q >= (timeout_i - CNT_W'(1)));

endmodule

// File: rtl/fsb_seq.sv
// FSB cycle sequencer: steers a 68000 bus cycle to ROM/RAM/IO/IACK and returns ready or bus error.
// Latency: every output is registered; ROM ready ROMWS+1 edges after IDLE exit, RAM/IO one edge after completion.
// Backpressure: holds ready/error until BACT drops; BACT low aborts any wait on the next edge.
module fsb_seq
  import fsb_seq_pkg::*;
#(
  parameter int unsigned ROMWS   = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic      FCLK,
  input  logic      nRES,
  fsb_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0]  TMO_C   = CNT_W'(TIMEOUT);
  localparam logic [ROMW_W-1:0] ROMWS_C = ROMW_W'(ROMWS);

  state_t            state_q, state_d;
  logic [ROMW_W-1:0] rom_q, rom_d;
  logic              ready_q, ready_d;
  logic              berr_q, berr_d;
  logic              ioreq_q, ioreq_d;
  logic              tmo_clr, tmo_en, tmo_exp;

  assign tmo_clr = (state_q == S_IDLE);
  assign tmo_en  = (state_q == S_ROMW) || (state_q == S_RAMW) ||
                   (state_q == S_IOWAITIDLE) || (state_q == S_IOREQ);

  fsb_timeout u_timeout (
    .FCLK      (FCLK),
    .nRES      (nRES),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .timeout_i (TMO_C),
    .expired_o (tmo_exp)
  );

  // Next state and next (registered) outputs; completion beats timeout, BACT low beats all.
  always_comb begin
    state_d = state_q;
    rom_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.BACT) begin
          if      (bus.IACS)  state_d = S_DONE;
          else if (bus.ROMCS) state_d = S_ROMW;
          else if (bus.RAMCS) state_d = S_RAMW;
          else if (bus.IOCS)  state_d = S_IOWAITIDLE;
          else                state_d = S_ERR;
        end
      end
      S_ROMW: begin
        rom_d = rom_q + ROMW_W'(1);
        if      (rom_q == ROMWS_C) state_d = S_DONE;
        else if (tmo_exp)          state_d = S_ERR;
      end
      S_RAMW: begin
        if      (bus.RAMReady) state_d = S_DONE;
        else if (tmo_exp)      state_d = S_ERR;
      end
      S_IOWAITIDLE: begin
        // Wait out a stale acknowledge before raising a fresh request.
        if      (tmo_exp)    state_d = S_ERR;
        else if (!bus.IOACK) state_d = S_IOREQ;
      end
      S_IOREQ: begin
        if      (bus.IOACK) state_d = bus.IOBERR ? S_ERR : S_DONE;
        else if (tmo_exp)   state_d = S_ERR;
      end
      S_DONE, S_ERR: begin
        if (!bus.BACT) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && !bus.BACT) begin
      state_d = S_IDLE;
    end
    ready_d = (state_d == S_DONE);
    berr_d  = (state_d == S_ERR);
    ioreq_d = (state_d == S_IOREQ);
  end

  // State, ROM wait count and output registers.
  always_ff @(posedge FCLK or negedge nRES) begin
    if (!nRES) begin
      state_q <= S_IDLE;
      rom_q   <= '0;
      ready_q <= 1'b0;
      berr_q  <= 1'b0;
      ioreq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rom_q   <= rom_d;
      ready_q <= ready_d;
      berr_q  <= berr_d;
      ioreq_q <= ioreq_d;
    end
  end

  assign bus.Ready0 = ready_q;
  assign bus.Ready1 = ready_q;
  assign bus.BERR0  = berr_q;
  assign bus.IOREQ  = ioreq_q;

endmodule

// File: tb/tb_fsb_seq.sv
// Directed bench for fsb_seq with a per-access behavioural model checked every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_fsb_seq;
  import fsb_seq_pkg::*;

  localparam int ROMWS   = 2;
  localparam int TIMEOUT = 255;

  logic FCLK;
  logic nRES;
  int   n_vec = 0;
  int   n_err = 0;

  fsb_seq_if bus ();

  fsb_seq #(.ROMWS(ROMWS), .TIMEOUT(TIMEOUT)) dut (
    .FCLK (FCLK),
    .nRES (nRES),
    .bus  (bus.slave)
  );

  initial begin
    FCLK = 1'b0;
    forever #5 FCLK = ~FCLK;
  end

  // Model: one access at a time; counts wait cycles and records its outcome.
  localparam int K_NONE = 0, K_ROM = 1, K_RAM = 2, K_IODRAIN = 3, K_IOREQ = 4;
  localparam int R_PEND = 0, R_OK = 1, R_ERR = 2;
  bit m_busy   = 0;
  int m_kind   = K_NONE;
  int m_result = R_PEND;
  int m_waited = 0;

  initial begin
    forever begin
      @(posedge FCLK or negedge nRES);
      if (!nRES) begin
        m_busy = 0; m_kind = K_NONE; m_result = R_PEND; m_waited = 0;
      end else if (!m_busy) begin
        if (bus.BACT) begin
          m_busy = 1; m_waited = 0; m_result = R_PEND; m_kind = K_NONE;
          if      (bus.IACS)  m_result = R_OK;
          else if (bus.ROMCS) m_kind = K_ROM;
          else if (bus.RAMCS) m_kind = K_RAM;
          else if (bus.IOCS)  m_kind = K_IODRAIN;
          else                m_result = R_ERR;
        end
      end else if (!bus.BACT) begin
        m_busy = 0; m_kind = K_NONE; m_result = R_PEND;
      end else if (m_result == R_PEND) begin
        m_waited++;
        case (m_kind)
          K_ROM:     if (m_waited == ROMWS + 1) m_result = R_OK;
                     else if (m_waited >= TIMEOUT) m_result = R_ERR;
          K_RAM:     if (bus.RAMReady) m_result = R_OK;
                     else if (m_waited >= TIMEOUT) m_result = R_ERR;
          K_IODRAIN: if (m_waited >= TIMEOUT) m_result = R_ERR;
                     else if (!bus.IOACK) m_kind = K_IOREQ;
          K_IOREQ:   if (bus.IOACK) m_result = bus.IOBERR ? R_ERR : R_OK;
                     else if (m_waited >= TIMEOUT) m_result = R_ERR;
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  initial begin
    logic e_rdy, e_berr, e_ioreq;
    forever begin
      @(negedge FCLK);
      e_rdy   = m_busy && (m_result == R_OK);
      e_berr  = m_busy && (m_result == R_ERR);
      e_ioreq = m_busy && (m_result == R_PEND) && (m_kind == K_IOREQ);
      n_vec++;
      if (bus.Ready0 !== e_rdy || bus.Ready1 !== e_rdy ||
          bus.BERR0 !== e_berr || bus.IOREQ !== e_ioreq) begin
        n_err++;
        $display("FAIL model t=%0t: got rdy0=%b rdy1=%b berr=%b ioreq=%b, expected rdy=%b berr=%b ioreq=%b",
                 $time, bus.Ready0, bus.Ready1, bus.BERR0, bus.IOREQ, e_rdy, e_berr, e_ioreq);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return bus.Ready0;
      1:       return bus.BERR0;
      default: return bus.IOREQ;
    endcase
  endfunction

  // Negedges until output w reaches lvl; -1 if the budget runs out.
  task automatic wait_lvl(input int w, input logic lvl, output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge FCLK);
      if (sig(w) == lvl) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic drive(input logic bact, input logic iacs, input logic romcs,
                       input logic ramcs, input logic iocs);
    bus.BACT = bact; bus.IACS = iacs; bus.ROMCS = romcs; bus.RAMCS = ramcs; bus.IOCS = iocs;
  endtask

  task automatic release_bus();
    @(negedge FCLK);
    drive(0, 0, 0, 0, 0);
    bus.RAMReady = 0; bus.IOACK = 0; bus.IOBERR = 0;
    repeat (2) @(negedge FCLK);
  endtask

  initial begin
    int n;
    nRES = 1'b0;
    drive(0, 0, 0, 0, 0);
    bus.RAMReady = 0; bus.IOACK = 0; bus.IOBERR = 0;

    // Reset state
    repeat (3) @(negedge FCLK);
    chk("reset Ready0", int'(bus.Ready0), 0);
    chk("reset BERR0", int'(bus.BERR0), 0);
    chk("reset IOREQ", int'(bus.IOREQ), 0);
    chk("reset state", int'(dut.state_q), int'(S_IDLE));
    nRES = 1'b1;
    repeat (2) @(negedge FCLK);

    // RAM: RAMReady three cycles after BACT, ready one edge later, cleared one edge after BACT low
    drive(1, 0, 0, 1, 0);
    repeat (3) @(negedge FCLK);
    bus.RAMReady = 1;
    wait_lvl(0, 1, n); chk("ram ready latency", n, 1);
    @(negedge FCLK);
    drive(0, 0, 0, 0, 0); bus.RAMReady = 0;
    wait_lvl(0, 0, n); chk("ram ready clear", n, 1);
    repeat (2) @(negedge FCLK);

    // ROM with two wait states: ready on 3rd edge after IDLE exit
    drive(1, 0, 1, 0, 0);
    wait_lvl(0, 1, n); chk("rom ready latency", n, 4);
    release_bus();

    // IO with stale IOACK for four cycles, then acknowledged with error
    bus.IOACK = 1;
    drive(1, 0, 0, 0, 1);
    repeat (4) @(negedge FCLK);
    chk("io no req on stale ack", int'(bus.IOREQ), 0);
    bus.IOACK = 0;
    wait_lvl(2, 1, n); chk("io req after ack low", n, 1);
    bus.IOACK = 1; bus.IOBERR = 1;
    wait_lvl(1, 1, n); chk("io berr latency", n, 1);
    chk("io req dropped on berr", int'(bus.IOREQ), 0);
    release_bus();

    // IO good completion
    drive(1, 0, 0, 0, 1);
    wait_lvl(2, 1, n); chk("io req latency", n, 2);
    bus.IOACK = 1;
    wait_lvl(0, 1, n); chk("io ready latency", n, 1);
    release_bus();

    // RAM timeout
    drive(1, 0, 0, 1, 0);
    wait_lvl(1, 1, n); chk("ram timeout latency", n, 256);
    release_bus();

    // RAMReady on the expiry edge: completion wins
    drive(1, 0, 0, 1, 0);
    repeat (255) @(negedge FCLK);
    bus.RAMReady = 1;
    wait_lvl(0, 1, n); chk("ready on expiry edge", n, 1);
    chk("no berr on expiry edge", int'(bus.BERR0), 0);
    release_bus();

    // No select: immediate bus error
    drive(1, 0, 0, 0, 0);
    wait_lvl(1, 1, n); chk("no-select berr latency", n, 1);
    release_bus();

    // IACS beats RAMCS: no RAM wait
    drive(1, 1, 0, 1, 0);
    wait_lvl(0, 1, n); chk("iack ready latency", n, 1);
    release_bus();

    // Abort in IOREQ: request withdrawn on the next edge
    drive(1, 0, 0, 0, 1);
    wait_lvl(2, 1, n); chk("abort setup ioreq", n, 2);
    drive(0, 0, 0, 0, 0);
    wait_lvl(2, 0, n); chk("abort ioreq drop", n, 1);
    repeat (2) @(negedge FCLK);

    // Asynchronous reset mid-IOREQ, release with BACT still high
    drive(1, 0, 0, 0, 1);
    wait_lvl(2, 1, n); chk("rst setup ioreq", n, 2);
    #2 nRES = 1'b0;
    #1;
    chk("async rst IOREQ", int'(bus.IOREQ), 0);
    chk("async rst Ready0", int'(bus.Ready0), 0);
    chk("async rst BERR0", int'(bus.BERR0), 0);
    chk("async rst state", int'(dut.state_q), int'(S_IDLE));
    @(negedge FCLK);
    nRES = 1'b1;
    wait_lvl(2, 1, n); chk("restart after reset", n, 2);
    release_bus();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fsb_seq.md
FSB_SEQ -- requirements
Module: fsb_seq

Interface
REQ-001 SHALL have parameter ROMWS, default 2, meaning the number of FCLK wait cycles for a ROM access (range 0..15).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the FCLK count before a bus-error timeout (range 1..255).
REQ-003 FCLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 nRES  in  1  asynchronous, active-low reset.
REQ-005 BACT  in  1  68000 bus cycle active, registered upstream from nAS.
REQ-006 IACS, ROMCS, RAMCS, IOCS  in  1 each  decoded selects, valid whenever BACT=1.
REQ-007 RAMReady  in  1  RAM controller reports access complete (level).
REQ-008 IOACK, IOBERR  in  1 each  IO bridge acknowledge, and bridge error qualifier sampled with IOACK.
REQ-009 IOREQ  out  1  request to the IO bridge (4-phase handshake).
REQ-010 Ready0  out  1  memory-side ready to FSB.
REQ-011 Ready1  out  1  IO-side ready to FSB.
REQ-012 BERR0  out  1  bus error to FSB.

Function
REQ-013 States SHALL be IDLE, ROMW, RAMW, IOWAITIDLE, IOREQ, DONE and ERR, with the state register and all outputs registered.
REQ-014 IDLE with BACT=1 SHALL select the next state by priority IACS > ROMCS > RAMCS > IOCS: IACS->DONE, ROMCS->ROMW, RAMCS->RAMW, IOCS->IOWAITIDLE, no select->ERR.
REQ-015 ROMW SHALL count ROMWS cycles, then go to DONE; with ROMWS=0, Ready0 and Ready1 SHALL assert on the edge after entry.
REQ-016 RAMW SHALL go to DONE on the edge where RAMReady=1.
REQ-017 IOWAITIDLE SHALL stay until IOACK=0, then go to IOREQ, so a new request never overlaps a stale acknowledge.
REQ-018 In IOREQ, IOREQ=1 until IOACK=1 is sampled, then IOREQ=0 and the next state SHALL be DONE if IOBERR=0, or ERR if IOBERR=1.
REQ-019 In DONE, Ready0=1 and Ready1=1, held until BACT=0.
REQ-020 In ERR, BERR0=1 (Ready0 and Ready1 stay 0), held until BACT=0.
REQ-021 An 8-bit timeout counter SHALL clear in IDLE and increment every cycle in ROMW, RAMW, IOWAITIDLE and IOREQ.
REQ-022 When the counter reaches TIMEOUT, the next state SHALL be ERR and IOREQ SHALL drop.
REQ-023 The counter SHALL saturate at TIMEOUT and never wrap.
REQ-024 On the same edge, RAMReady or IOACK SHALL take priority over the timeout (completion wins).
REQ-025 BACT=0 in any non-IDLE state SHALL return to IDLE on the next edge and clear Ready0, Ready1, BERR0 and IOREQ (abort); the bridge tolerates an IOREQ withdrawn before IOACK.
REQ-026 From DONE or ERR, BACT=0 SHALL return to IDLE; a new cycle SHALL NOT be accepted on that same edge.
REQ-027 Ready0/Ready1 and BERR0 SHALL never be 1 simultaneously.

Reset
REQ-028 nRES=0 SHALL asynchronously force IDLE, counter=0, and IOREQ=Ready0=Ready1=BERR0=0.
REQ-029 Release of nRES SHALL take effect at the first FCLK edge with nRES=1; BACT already high at release SHALL start a cycle from IDLE normally.

Structure
REQ-030 State encodings and the counter width (8) SHALL live in a shared fsb_defs include/package, also used by the FSB block.
REQ-031 The timeout counter SHALL be a sub-module fsb_timeout (inputs clr, en, TIMEOUT; output expired).
REQ-032 The block SHALL contain no combinational path from any input to any output.

Verification
REQ-033 RAMCS=1, RAMReady asserted 3 cycles after BACT -> Ready0=Ready1=1 exactly one edge later, cleared one edge after BACT=0.
REQ-034 ROMCS=1, ROMWS=2 -> Ready0=Ready1=1 on the 3rd edge after the IDLE exit, with BERR0=0 throughout.
REQ-035 IOCS=1 with IOACK stuck 1 for 4 cycles -> IOREQ stays 0 until IOACK=0, then rises; IOACK=1 with IOBERR=1 -> BERR0=1, IOREQ=0.
REQ-036 RAMCS=1 with RAMReady never asserted, TIMEOUT=255 -> BERR0=1 after 255 counted cycles; a variant with RAMReady on the expiry edge -> Ready0=1, BERR0=0.
REQ-037 No select with BACT=1 -> BERR0=1 on the next edge; IACS plus RAMCS -> DONE with no RAM wait.
REQ-038 Pulsing nRES low mid-IOREQ -> all outputs 0 immediately (asynchronously), state=IDLE.
